// File: rtl/memory_responder_if.sv
// Bundle of request-unit and RAM signals around memory_responder.
// slave: the responder's view; master: the requester/RAM environment's view.
interface memory_responder_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        ihit;
    logic        dhit;
    logic [31:0] imemload;
    logic [31:0] dmemload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ram_ready;
    logic        busy;
    logic        err;

    modport slave (
        input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
        input  ramload, ram_ready,
        output ihit, dhit, imemload, dmemload,
        output ramREN, ramWEN, ramaddr, ramstore, busy, err
    );

    modport master (
        output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
        output ramload, ram_ready,
        input  ihit, dhit, imemload, dmemload,
        input  ramREN, ramWEN, ramaddr, ramstore, busy, err
    );
endinterface

// File: rtl/memory_responder.sv
// Single-ported RAM responder: arbitrates data (priority) and instruction requests,
// one transaction at a time. Define RESP_STATS_EN to add hit/error counters.
module memory_responder #(
    parameter int TIMEOUT = 255
) (
    input  logic                clk_i,
    input  logic                nrst_i,
    memory_responder_if.slave   bus_io
`ifdef RESP_STATS_EN
    ,
    output logic [31:0]         icount_o,
    output logic [31:0]         dcount_o,
    output logic [15:0]         errcount_o
`endif
);

    localparam logic [7:0]  WAIT_LAST    = 8'(TIMEOUT - 1);
    localparam logic [31:0] TIMEOUT_WORD = 32'hBAD1BAD1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DRD  = 3'd1,
        DWR  = 3'd2,
        IRD  = 3'd3,
        RESP = 3'd4
    } state_e;

    state_e      state_q;
    logic [31:0] addr_q;
    logic [31:0] store_q;
    logic        src_d_q;
    logic [7:0]  wait_q;
    logic        err_pend_q;
    logic        ramren_q;
    logic        ramwen_q;
    logic        ihit_q;
    logic        dhit_q;
    logic        err_q;
    logic        busy_q;
    logic [31:0] imemload_q;
    logic [31:0] dmemload_q;

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            store_q    <= '0;
            src_d_q    <= 1'b0;
            wait_q     <= '0;
            err_pend_q <= 1'b0;
            ramren_q   <= 1'b0;
            ramwen_q   <= 1'b0;
            ihit_q     <= 1'b0;
            dhit_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            imemload_q <= '0;
            dmemload_q <= '0;
        end else begin
            ihit_q <= 1'b0;
            dhit_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    wait_q <= '0;
                    if (bus_io.dmemWEN) begin
                        // A simultaneous read request is dropped and flagged as an error.
                        state_q    <= DWR;
                        ramwen_q   <= 1'b1;
                        busy_q     <= 1'b1;
                        addr_q     <= bus_io.dmemaddr;
                        store_q    <= bus_io.dmemstore;
                        src_d_q    <= 1'b1;
                        err_pend_q <= bus_io.dmemREN;
                    end else if (bus_io.dmemREN) begin
                        state_q    <= DRD;
                        ramren_q   <= 1'b1;
                        busy_q     <= 1'b1;
                        addr_q     <= bus_io.dmemaddr;
                        src_d_q    <= 1'b1;
                        err_pend_q <= 1'b0;
                    end else if (bus_io.imemREN) begin
                        state_q    <= IRD;
                        ramren_q   <= 1'b1;
                        busy_q     <= 1'b1;
                        addr_q     <= bus_io.imemaddr;
                        src_d_q    <= 1'b0;
                        err_pend_q <= 1'b0;
                    end
                end
                DRD, DWR, IRD: begin
                    // ram_ready wins over a timeout landing on the same edge.
                    if (bus_io.ram_ready || (wait_q == WAIT_LAST)) begin
                        state_q    <= RESP;
                        ramren_q   <= 1'b0;
                        ramwen_q   <= 1'b0;
                        ihit_q     <= ~src_d_q;
                        dhit_q     <= src_d_q;
                        err_q      <= err_pend_q | ~bus_io.ram_ready;
                        err_pend_q <= 1'b0;
                        if (!bus_io.ram_ready) begin
                            if (src_d_q) dmemload_q <= TIMEOUT_WORD;
                            else         imemload_q <= TIMEOUT_WORD;
                        end else if (state_q == IRD) begin
                            imemload_q <= bus_io.ramload;
                        end else if (state_q == DRD) begin
                            dmemload_q <= bus_io.ramload;
                        end
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    ramren_q <= 1'b0;
                    ramwen_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus_io.ihit     = ihit_q;
    assign bus_io.dhit     = dhit_q;
    assign bus_io.err      = err_q;
    assign bus_io.busy     = busy_q;
    assign bus_io.ramREN   = ramren_q;
    assign bus_io.ramWEN   = ramwen_q;
    assign bus_io.ramaddr  = addr_q;
    assign bus_io.ramstore = store_q;
    assign bus_io.imemload = imemload_q;
    assign bus_io.dmemload = dmemload_q;

`ifdef RESP_STATS_EN
    logic [31:0] icount_q;
    logic [31:0] dcount_q;
    logic [15:0] errcount_q;

    // Counters follow the hit/err pulses and stick at all-ones.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            icount_q   <= '0;
            dcount_q   <= '0;
            errcount_q <= '0;
        end else begin
            if (ihit_q && (icount_q != '1))   icount_q   <= icount_q + 32'd1;
            if (dhit_q && (dcount_q != '1))   dcount_q   <= dcount_q + 32'd1;
            if (err_q  && (errcount_q != '1)) errcount_q <= errcount_q + 16'd1;
        end
    end

    assign icount_o   = icount_q;
    assign dcount_o   = dcount_q;
    assign errcount_o = errcount_q;
`endif

endmodule

// File: tb/tb_memory_responder.sv
// Self-checking bench for memory_responder: directed scenarios plus random traffic
// checked against a word-addressed memory model.
module tb_memory_responder;
    localparam int TMO = 8;

    logic clk;
    logic nrst;
    int   checks   = 0;
    int   failures = 0;
    int   txn_no   = 0;

    memory_responder_if bus ();

`ifdef RESP_STATS_EN
    logic [31:0] icount;
    logic [31:0] dcount;
    logic [15:0] errcount;
`endif

    memory_responder #(.TIMEOUT(TMO)) dut (
        .clk_i  (clk),
        .nrst_i (nrst),
        .bus_io (bus)
`ifdef RESP_STATS_EN
        ,
        .icount_o   (icount),
        .dcount_o   (dcount),
        .errcount_o (errcount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation did not finish");
    end

    // RAM device contents (driven from DUT outputs) and reference memory (from requests).
    logic [31:0] ram_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] fill(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : fill(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : fill(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Entered and left at a negedge; delay >= TMO means RAM never answers.
    task automatic txn(input logic iren, input logic dren, input logic dwen,
                       input logic [31:0] iaddr, input logic [31:0] daddr,
                       input logic [31:0] dstore, input int delay, input bit keep_i);
        logic        is_d, is_w, exp_err, tmo;
        logic [31:0] eaddr, edata;
        int          n;
        is_w    = dwen;
        is_d    = dwen | dren;
        exp_err = dwen & dren;
        eaddr   = is_d ? daddr : iaddr;
        tmo     = (delay >= TMO);
        n       = tmo ? TMO : delay + 1;
        txn_no++;
        $display("txn %0d: kind=%s addr=%h delay=%0d", txn_no,
                 is_w ? "DWR" : (is_d ? "DRD" : "IRD"), eaddr, delay);
        bus.imemREN   = iren;
        bus.imemaddr  = iaddr;
        bus.dmemREN   = dren;
        bus.dmemWEN   = dwen;
        bus.dmemaddr  = daddr;
        bus.dmemstore = dstore;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check("ramREN", 32'(bus.ramREN), 32'(!is_w));
            check("ramWEN", 32'(bus.ramWEN), 32'(is_w));
            check("ramaddr", bus.ramaddr, eaddr);
            if (is_w) check("ramstore", bus.ramstore, dstore);
            check("busy_access", 32'(bus.busy), 32'd1);
            check("hit_during_access", 32'({bus.ihit, bus.dhit}), 32'd0);
            if (!tmo && k == n - 1) begin
                bus.ram_ready = 1'b1;
                bus.ramload   = ram_rd(bus.ramaddr);
                if (is_w) ram_mem[bus.ramaddr] = bus.ramstore;
            end
        end
        @(negedge clk);
        bus.ram_ready = 1'b0;
        bus.ramload   = $urandom;
        edata = tmo ? 32'hBAD1BAD1 : ref_rd(eaddr);
        if (!tmo && is_w) ref_mem[eaddr] = dstore;
        check("ihit", 32'(bus.ihit), 32'(!is_d));
        check("dhit", 32'(bus.dhit), 32'(is_d));
        check("err", 32'(bus.err), 32'(exp_err | tmo));
        check("strobes_resp", 32'({bus.ramREN, bus.ramWEN}), 32'd0);
        if (!is_w) check(is_d ? "dmemload" : "imemload", is_d ? bus.dmemload : bus.imemload, edata);
        bus.dmemREN = 1'b0;
        bus.dmemWEN = 1'b0;
        if (!keep_i) bus.imemREN = 1'b0;
        @(negedge clk);
        check("busy_idle", 32'(bus.busy), 32'd0);
        check("hits_idle", 32'({bus.ihit, bus.dhit, bus.err}), 32'd0);
        check("strobes_idle", 32'({bus.ramREN, bus.ramWEN}), 32'd0);
        if (!is_w) check(is_d ? "dmemload_held" : "imemload_held",
                         is_d ? bus.dmemload : bus.imemload, edata);
    endtask

    initial begin
        logic [2:0] r;
        int         d;
        nrst          = 1'b0;
        bus.imemREN   = 1'b0;
        bus.imemaddr  = '0;
        bus.dmemREN   = 1'b0;
        bus.dmemWEN   = 1'b0;
        bus.dmemaddr  = '0;
        bus.dmemstore = '0;
        bus.ramload   = '0;
        bus.ram_ready = 1'b0;

        // 1) reset state
        repeat (2) @(negedge clk);
        check("rst_ihit", 32'(bus.ihit), 32'd0);
        check("rst_dhit", 32'(bus.dhit), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_strobes", 32'({bus.ramREN, bus.ramWEN}), 32'd0);
        check("rst_ramaddr", bus.ramaddr, 32'd0);
        check("rst_ramstore", bus.ramstore, 32'd0);
        check("rst_imemload", bus.imemload, 32'd0);
        check("rst_dmemload", bus.dmemload, 32'd0);
        nrst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("idle_quiet", 32'({bus.ramREN, bus.ramWEN, bus.busy, bus.ihit, bus.dhit}), 32'd0);
        end

        // 2) instruction fetch, ready one cycle after strobe rise
        ram_mem[32'h40] = 32'h8C010004;
        ref_mem[32'h40] = 32'h8C010004;
        txn(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 0, 1'b0);

        // 3) simultaneous fetch and data read: data first, fetch after one IDLE cycle
        txn(1'b1, 1'b1, 1'b0, 32'h44, 32'h80, 32'h0, 0, 1'b1);
        txn(1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 32'h0, 0, 1'b0);

        // 4) delayed write
        txn(1'b0, 1'b0, 1'b1, 32'h0, 32'h100, 32'hDEADBEEF, 4, 1'b0);
        txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h100, 32'h0, 1, 1'b0);

        // 5) read with no RAM response -> timeout
        txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h200, 32'h0, 99, 1'b0);

        // read+write conflict is served as a write with err
        txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h104, 32'h0BADF00D, 2, 1'b0);

        // 6) asynchronous reset during a data read
        bus.dmemREN  = 1'b1;
        bus.dmemaddr = 32'h300;
        @(negedge clk);
        check("pre_rst_ramREN", 32'(bus.ramREN), 32'd1);
        #2 nrst = 1'b0;
        #1;
        check("async_rst_strobes", 32'({bus.ramREN, bus.ramWEN, bus.busy}), 32'd0);
        @(negedge clk);
        bus.dmemREN = 1'b0;
        nrst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("no_hit_after_rst", 32'({bus.ihit, bus.dhit, bus.busy}), 32'd0);
        end
`ifdef RESP_STATS_EN
        check("icount_rst", icount, 32'd0);
        check("dcount_rst", dcount, 32'd0);
        check("errcount_rst", 32'(errcount), 32'd0);
`endif

        // random traffic against the memory model
        for (int t = 0; t < 40; t++) begin
            r = 3'($urandom_range(1, 7));
            d = ($urandom_range(0, 9) == 0) ? 99 : int'($urandom_range(0, 5));
            txn(r[0], r[1], r[2], {26'd0, 4'($urandom_range(0, 15)), 2'b00},
                {26'd0, 4'($urandom_range(0, 15)), 2'b00}, $urandom, d, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
